// File: rtl/ball_controller.sv
// rtl/ball_controller.sv - frame-rate ball motion sequencer for the pong field
module ball_controller #(
    parameter int FIELD_W      = 640,
    parameter int FIELD_H      = 480,
    parameter int BALL_HALF    = 4,
    parameter int SPEED        = 2,
    parameter int PADDLE_HALF  = 32,
    parameter int LEFT_FACE_X  = 24,
    parameter int RIGHT_FACE_X = 616,
    parameter int SERVE_DELAY  = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [9:0] left_paddle_loc,
    input  logic [9:0] right_paddle_loc,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       left_point,
    output logic       right_point,
    output logic       serving
);
    localparam int CNT_W = $clog2(SERVE_DELAY + 1);

    localparam logic [9:0]         MID_X    = 10'(FIELD_W / 2);
    localparam logic [9:0]         MID_Y    = 10'(FIELD_H / 2);
    localparam logic signed [10:0] STEP     = 11'(SPEED);
    localparam logic signed [10:0] TOP_Y    = 11'(BALL_HALF);
    localparam logic signed [10:0] BOT_Y    = 11'(FIELD_H - BALL_HALF);
    localparam logic signed [10:0] L_GOAL_X = 11'(BALL_HALF);
    localparam logic signed [10:0] R_GOAL_X = 11'(FIELD_W - BALL_HALF);
    localparam logic signed [10:0] L_HIT_X  = 11'(LEFT_FACE_X + BALL_HALF);
    localparam logic signed [10:0] R_HIT_X  = 11'(RIGHT_FACE_X - BALL_HALF);
    localparam logic signed [10:0] REACH    = 11'(PADDLE_HALF + BALL_HALF);
    localparam logic [CNT_W-1:0]   DELAY    = CNT_W'(SERVE_DELAY);

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        WAIT_TICK,
        MOVE,
        COLLIDE,
        POINT
    } state_t;

    state_t             state, state_d;
    logic [9:0]         ball_x_d, ball_y_d;
    logic               dx_neg, dx_neg_d;
    logic               dy_pos, dy_pos_d;
    logic               score_right, score_right_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic signed [10:0] nx, ny, nx_d, ny_d;
    logic signed [10:0] bx, by, cy, pdiff;

    // One spare sign bit keeps a step off the left/top edge from wrapping.
    assign bx = $signed({1'b0, ball_x});
    assign by = $signed({1'b0, ball_y});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ball_x      <= MID_X;
            ball_y      <= MID_Y;
            dx_neg      <= 1'b1;
            dy_pos      <= 1'b1;
            score_right <= 1'b0;
            cnt         <= '0;
            nx          <= '0;
            ny          <= '0;
        end else begin
            state       <= state_d;
            ball_x      <= ball_x_d;
            ball_y      <= ball_y_d;
            dx_neg      <= dx_neg_d;
            dy_pos      <= dy_pos_d;
            score_right <= score_right_d;
            cnt         <= cnt_d;
            nx          <= nx_d;
            ny          <= ny_d;
        end
    end

    always_comb begin
        state_d       = state;
        ball_x_d      = ball_x;
        ball_y_d      = ball_y;
        dx_neg_d      = dx_neg;
        dy_pos_d      = dy_pos;
        score_right_d = score_right;
        cnt_d         = cnt;
        nx_d          = nx;
        ny_d          = ny;
        cy            = '0;
        pdiff         = '0;

        if (!enable) begin
            state_d  = IDLE;
            ball_x_d = MID_X;
            ball_y_d = MID_Y;
        end else begin
            case (state)
                IDLE: begin
                    ball_x_d = MID_X;
                    ball_y_d = MID_Y;
                    cnt_d    = DELAY;
                    state_d  = SERVE;
                end
                SERVE: begin
                    ball_x_d = MID_X;
                    ball_y_d = MID_Y;
                    if (frame_tick) begin
                        cnt_d = cnt - CNT_W'(1);
                        if (cnt <= CNT_W'(1)) state_d = WAIT_TICK;
                    end
                end
                WAIT_TICK: begin
                    if (frame_tick) state_d = MOVE;
                end
                MOVE: begin
                    nx_d    = dx_neg ? bx - STEP : bx + STEP;
                    ny_d    = dy_pos ? by + STEP : by - STEP;
                    state_d = COLLIDE;
                end
                COLLIDE: begin
                    if (ny <= TOP_Y) begin
                        cy       = TOP_Y;
                        dy_pos_d = 1'b1;
                    end else if (ny >= BOT_Y) begin
                        cy       = BOT_Y;
                        dy_pos_d = 1'b0;
                    end else begin
                        cy = ny;
                    end
                    ball_y_d = cy[9:0];
                    state_d  = WAIT_TICK;
                    // Paddle reach is judged against the wall-corrected y.
                    if (dx_neg) begin
                        pdiff = cy - $signed({1'b0, left_paddle_loc});
                        if (nx <= L_HIT_X && pdiff >= -REACH && pdiff <= REACH) begin
                            ball_x_d = L_HIT_X[9:0];
                            dx_neg_d = 1'b0;
                        end else if (nx <= L_GOAL_X) begin
                            score_right_d = 1'b1;
                            state_d       = POINT;
                        end else begin
                            ball_x_d = nx[9:0];
                        end
                    end else begin
                        pdiff = cy - $signed({1'b0, right_paddle_loc});
                        if (nx >= R_HIT_X && pdiff >= -REACH && pdiff <= REACH) begin
                            ball_x_d = R_HIT_X[9:0];
                            dx_neg_d = 1'b1;
                        end else if (nx >= R_GOAL_X) begin
                            score_right_d = 1'b0;
                            state_d       = POINT;
                        end else begin
                            ball_x_d = nx[9:0];
                        end
                    end
                end
                POINT: begin
                    ball_x_d = MID_X;
                    ball_y_d = MID_Y;
                    // Next serve heads toward whoever conceded.
                    dx_neg_d = score_right;
                    cnt_d    = DELAY;
                    state_d  = SERVE;
                end
                default: begin
                    state_d  = IDLE;
                    ball_x_d = MID_X;
                    ball_y_d = MID_Y;
                end
            endcase
        end
    end

    always_comb begin
        serving     = (state == IDLE) || (state == SERVE);
        left_point  = enable && (state == POINT) && !score_right;
        right_point = enable && (state == POINT) && score_right;
    end
endmodule
